dmem_access_ctrl: RTL and testbench



---
 rtl/dmem_access_ctrl_if.sv | 30 +++
 rtl/dmem_access_ctrl.sv | 106 ++++++++++
 tb/tb_dmem_access_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: MEM-stage request/response plus data-memory array bus.
// slave  = the access controller; master = its environment (pipeline + array).
interface dmem_access_ctrl_if #(
   parameter int ADDR_W = 6
);
   // pipeline side
   logic              rd_en;
   logic              wr_en;
   logic [31:0]       addr;
   logic [31:0]       wr_data;
   logic [31:0]       rd_data;
   logic              ready;
   logic              err;
   // memory-array side
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic              mem_oe;
   logic [31:0]       mem_rdata;

   modport slave (
      input  rd_en, wr_en, addr, wr_data, mem_rdata,
      output rd_data, ready, err, mem_addr, mem_wdata, mem_we, mem_oe
   );

   modport master (
      output rd_en, wr_en, addr, wr_data, mem_rdata,
      input  rd_data, ready, err, mem_addr, mem_wdata, mem_we, mem_oe
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto a multi-cycle,
// word-organised data memory. The byte address is rebased by BASE_ADDR and
// word-aligned; the strobe is held WAIT_CYCLES cycles and the pipeline is
// frozen through `ready` until the access completes.
// Optional build macro DMEM_BOUNDS_CHECK_EN: out-of-window or misaligned
// requests skip the memory and raise err for one cycle. Without it err is
// constant 0 and addresses wrap into the ADDR_W word window.
module dmem_access_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          ADDR_W      = 6,
   parameter int          WAIT_CYCLES = 4
) (
   input logic               clk,
   input logic               rst,
   dmem_access_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              we_q;
   logic              oe_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic              req;
   logic [31:0]       offs;
   logic              bad;
   logic              unused_offs;

   assign req  = bus.rd_en | bus.wr_en;
   // modulo-2^32 rebase; only [ADDR_W+1:2] reaches the array
   assign offs = bus.addr - BASE_ADDR;
   assign unused_offs = ^offs;

`ifdef DMEM_BOUNDS_CHECK_EN
   localparam logic [31:0] WIN_BYTES = 32'(4) << ADDR_W;
   assign bad = (offs >= WIN_BYTES) || (bus.addr[1:0] != 2'b00);
`else
   // no range check: every request goes to memory, err_q never sets
   assign bad = 1'b0;
`endif

   // request/strobe/capture sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         oe_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               err_q <= 1'b0;
               if (req) begin
                  if (bad) begin
                     // flagged: no strobes, straight to the release cycle
                     err_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     // a simultaneous rd_en/wr_en is a write
                     addr_q  <= offs[ADDR_W+1:2];
                     wdata_q <= bus.wr_data;
                     we_q    <= bus.wr_en;
                     oe_q    <= ~bus.wr_en;
                     cnt     <= 4'(WAIT_CYCLES - 1);
                     state   <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  if (oe_q) rdata_q <= bus.mem_rdata;
                  we_q  <= 1'b0;
                  oe_q  <= 1'b0;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               // one release cycle; a still-high request is the old instruction
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready     = ((state == IDLE) && !req) || (state == DONE);
   assign bus.err       = err_q;
   assign bus.rd_data   = rdata_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_oe    = oe_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed vectors against dmem_access_ctrl with a
// 64-word array model; expected values are hand-computed constants.
module tb_dmem_access_ctrl;

   logic clk = 1'b0;
   logic rst;

   dmem_access_ctrl_if #(.ADDR_W(6)) bus ();

   dmem_access_ctrl #(
      .BASE_ADDR  (32'd1024),
      .ADDR_W     (6),
      .WAIT_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // data-memory array model
   logic [31:0] mem [64];
   initial for (int i = 0; i < 64; i++) mem[i] = 32'd0;
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr];

   int n_chk = 0;
   int n_err = 0;

   // per-access observations
   int          rlo, nwe, noe, nerrc;
   logic        seen, stable, done_ok, derr;
   logic [31:0] saddr, swdata, drd;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // issue one request at posedge+1 in IDLE, hold it one cycle, then
   // scramble inputs and observe until the release (ready high) cycle
   task automatic do_access(input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
      bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.wr_data = d;
      rlo = 0; nwe = 0; noe = 0; nerrc = 0;
      seen = 1'b0; stable = 1'b1; done_ok = 1'b0; derr = 1'b0;
      saddr = 32'd0; swdata = 32'd0; drd = 32'd0;
      for (int i = 0; i < 20 && !done_ok; i++) begin
         #1;
         if (bus.err) nerrc++;
         if (bus.mem_we) nwe++;
         if (bus.mem_oe) noe++;
         if (bus.mem_we || bus.mem_oe) begin
            if (!seen) begin
               saddr = 32'(bus.mem_addr); swdata = bus.mem_wdata; seen = 1'b1;
            end else if (saddr != 32'(bus.mem_addr) || swdata != bus.mem_wdata) begin
               stable = 1'b0;
            end
         end
         if (bus.ready) begin
            done_ok = 1'b1; drd = bus.rd_data; derr = bus.err;
         end else begin
            rlo++;
         end
         @(posedge clk); #1;
         bus.rd_en = 1'b0; bus.wr_en = 1'b0;
         bus.addr = 32'hFFFF_FFF0; bus.wr_data = 32'h1234_5678;
      end
      chk("access_completes", 32'(done_ok), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = 32'd0; bus.wr_data = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_ready",  32'(bus.ready),     32'd1);
      chk("rst_we",     32'(bus.mem_we),    32'd0);
      chk("rst_oe",     32'(bus.mem_oe),    32'd0);
      chk("rst_addr",   32'(bus.mem_addr),  32'd0);
      chk("rst_wdata",  bus.mem_wdata,      32'd0);
      chk("rst_rdata",  bus.rd_data,        32'd0);
      chk("rst_err",    32'(bus.err),       32'd0);
      @(posedge clk); #1;

      // write 1032 -> word 2
      do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
      chk("wr_ready_lo", rlo, 5);
      chk("wr_we_cyc",   nwe, 4);
      chk("wr_oe_cyc",   noe, 0);
      chk("wr_addr",     saddr, 32'd2);
      chk("wr_wdata",    swdata, 32'hDEADBEEF);
      chk("wr_stable",   32'(stable), 32'd1);
      chk("wr_rdata",    drd, 32'd0);

      // read 1032
      do_access(1'b1, 1'b0, 32'd1032, 32'd0);
      chk("rd_ready_lo", rlo, 5);
      chk("rd_oe_cyc",   noe, 4);
      chk("rd_we_cyc",   nwe, 0);
      chk("rd_addr",     saddr, 32'd2);
      chk("rd_done_data", drd, 32'hDEADBEEF);
      chk("rd_hold",     bus.rd_data, 32'hDEADBEEF);

      // write 1036 leaves rd_data alone
      do_access(1'b0, 1'b1, 32'd1036, 32'h1111_1111);
      chk("wr2_addr",  saddr, 32'd3);
      chk("wr2_rdata", drd, 32'hDEADBEEF);

      // rd_en and wr_en together -> write at word 0
      do_access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D);
      chk("both_we_cyc", nwe, 4);
      chk("both_oe_cyc", noe, 0);
      chk("both_addr",   saddr, 32'd0);
      chk("both_wdata",  swdata, 32'hCAFEF00D);
      chk("both_rdata",  drd, 32'hDEADBEEF);

      // read back word 3
      do_access(1'b1, 1'b0, 32'd1036, 32'd0);
      chk("rd2_data", drd, 32'h1111_1111);

      // last word of the window
      do_access(1'b0, 1'b1, 32'd1276, 32'h0BADF00D);
      chk("top_addr",  saddr, 32'd63);
      chk("top_we",    nwe, 4);
      chk("top_err",   32'(derr), 32'd0);

      // reset during the 2nd ACCESS cycle of a write
      bus.wr_en = 1'b1; bus.addr = 32'd1040; bus.wr_data = 32'hA5A5A5A5;
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      @(posedge clk); #1;
      chk("abort_we_before", 32'(bus.mem_we), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_we",    32'(bus.mem_we), 32'd0);
      chk("abort_oe",    32'(bus.mem_oe), 32'd0);
      chk("abort_ready", 32'(bus.ready),  32'd1);
      chk("abort_rdata", bus.rd_data,     32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      do_access(1'b1, 1'b0, 32'd1032, 32'd0);
      chk("post_rst_ready_lo", rlo, 5);
      chk("post_rst_rdata",    drd, 32'hDEADBEEF);

      // read 1024+256: one word past the window
      do_access(1'b1, 1'b0, 32'd1280, 32'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
      chk("oob_ready_lo", rlo, 1);
      chk("oob_strobes",  nwe + noe, 0);
      chk("oob_err_done", 32'(derr), 32'd1);
      chk("oob_err_cyc",  nerrc, 1);
      chk("oob_rdata",    drd, 32'hDEADBEEF);
`else
      chk("oob_ready_lo", rlo, 5);
      chk("oob_oe_cyc",   noe, 4);
      chk("oob_addr",     saddr, 32'd0);
      chk("oob_err_cyc",  nerrc, 0);
      chk("oob_rdata",    drd, 32'hCAFEF00D);
`endif
      chk("oob_err_after", 32'(bus.err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // hard stop in case the sequence above stalls
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
